layer_compositor: RTL

Parametrised N-layer sprite compositor for the VGA pixel path. It sits between the VGA timing generator and the DAC output register. For every pixel it hit-tests up to `NUM_LAYERS` rectangular sprites and drives per-layer ROM addresses with integer scaling and optional horizontal scroll. It then resolves colour-key transparency and fixed priority, and applies a per-layer dim mask, returning one 24-bit colour per pixel with a fixed pipeline latency.

---
 rtl/compositor_pkg.sv | 18 +
 rtl/layer_addr_gen.sv | 63 ++++++
 rtl/layer_compositor.sv | 104 ++++++++++
 3 files changed

// File: rtl/compositor_pkg.sv
// Shared widths, default colour constants and the per-layer field slice helper
// for the layer compositor.
package compositor_pkg;

  localparam int PIX_W    = 16;
  localparam int TEX_W    = 16;
  localparam int COLOUR_W = 24;

  localparam logic [COLOUR_W-1:0] KEY_COLOUR_DEF = 24'hFF0096;
  localparam logic [COLOUR_W-1:0] BG_COLOUR_DEF  = 24'h70C5CE;
  localparam logic [COLOUR_W-1:0] DIM_MASK_DEF   = 24'h3F3F3F;

  // Low bit of field idx inside a flat vector of equally sized fields.
  function automatic int field_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/layer_addr_gen.sv
// One sprite layer: hit test, integer-scaled texel addressing and a wrapping
// horizontal scroll offset, with the S1 pipeline registers.
module layer_addr_gen
  import compositor_pkg::*;
#(
  parameter int SCALE_LOG2  = 1,
  parameter int WRAP_X      = 640,
  parameter int SCROLL_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] x,
  input  logic [PIX_W-1:0] y,
  input  logic [PIX_W-1:0] org_x,
  input  logic [PIX_W-1:0] org_y,
  input  logic [TEX_W-1:0] w,
  input  logic [TEX_W-1:0] h,
  input  logic             en,
  input  logic             scroll_en,
  input  logic             scroll_tick,
  output logic [TEX_W-1:0] row,
  output logic [TEX_W-1:0] col,
  output logic             hit
);

  localparam int SPAN_W = PIX_W + SCALE_LOG2;
  localparam logic [PIX_W:0] WRAP = (PIX_W+1)'(WRAP_X);
  localparam logic [PIX_W:0] STEP = (PIX_W+1)'(SCROLL_STEP);

  logic [PIX_W-1:0]  dx, dy, ofs, src_x, ofs_next;
  logic [SPAN_W-1:0] w_span, h_span;
  logic [PIX_W:0]    sum, sum_wrapped, ofs_sum;
  logic              hit_now;

  // Spans are widened so that a large size shifted by the scale cannot overflow.
  assign dx      = x - org_x;
  assign dy      = y - org_y;
  assign w_span  = SPAN_W'(w) << SCALE_LOG2;
  assign h_span  = SPAN_W'(h) << SCALE_LOG2;
  assign hit_now = en && (SPAN_W'(dx) < w_span) && (SPAN_W'(dy) < h_span);

  assign sum         = {1'b0, dx} + {1'b0, ofs};
  assign sum_wrapped = (sum >= WRAP) ? sum - WRAP : sum;
  assign src_x       = scroll_en ? PIX_W'(sum_wrapped) : dx;

  assign ofs_sum  = {1'b0, ofs} + STEP;
  assign ofs_next = PIX_W'((ofs_sum >= WRAP) ? ofs_sum - WRAP : ofs_sum);

  always_ff @(posedge clk) begin
    if (!rst) begin
      row <= '0;
      col <= '0;
      hit <= 1'b0;
      ofs <= '0;
    end else begin
      row <= TEX_W'(dy >> SCALE_LOG2);
      col <= TEX_W'(src_x >> SCALE_LOG2);
      hit <= hit_now;
      if (scroll_tick && scroll_en) ofs <= ofs_next;
    end
  end

endmodule

// File: rtl/layer_compositor.sv
// N-layer sprite compositor: per-layer address generators feed the ROMs, then a
// fixed-priority colour-key resolver with dimming produces RGB three clocks later.
module layer_compositor
  import compositor_pkg::*;
#(
  parameter int                  NUM_LAYERS  = 4,
  parameter int                  SCALE_LOG2  = 1,
  parameter int                  WRAP_X      = 640,
  parameter int                  SCROLL_STEP = 1,
  parameter logic [COLOUR_W-1:0] KEY_COLOUR  = KEY_COLOUR_DEF,
  parameter logic [COLOUR_W-1:0] BG_COLOUR   = BG_COLOUR_DEF,
  parameter logic [COLOUR_W-1:0] DIM_MASK    = DIM_MASK_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           display_on,
  input  logic [PIX_W-1:0]               X,
  input  logic [PIX_W-1:0]               Y,
  input  logic [NUM_LAYERS-1:0]          layer_en,
  input  logic [NUM_LAYERS-1:0]          scroll_en,
  input  logic                           scroll_tick,
  input  logic [NUM_LAYERS:0]            dim_mask,
  input  logic [PIX_W*NUM_LAYERS-1:0]    layer_x,
  input  logic [PIX_W*NUM_LAYERS-1:0]    layer_y,
  input  logic [TEX_W*NUM_LAYERS-1:0]    layer_w,
  input  logic [TEX_W*NUM_LAYERS-1:0]    layer_h,
  output logic [TEX_W*NUM_LAYERS-1:0]    rom_row,
  output logic [TEX_W*NUM_LAYERS-1:0]    rom_col,
  input  logic [COLOUR_W*NUM_LAYERS-1:0] rom_colour,
  output logic [COLOUR_W-1:0]            RGB,
  output logic                           rgb_valid
);

  localparam int N = NUM_LAYERS;

  logic [N-1:0]          hit_s1, hit_s2;
  logic [N:0]            dim_s1, dim_s2;
  logic                  disp_s1, disp_s2;
  logic [COLOUR_W-1:0]   win_colour;
  logic                  win_dim, found;

  for (genvar i = 0; i < N; i++) begin : g_layer
    localparam int PLO = field_lo(i, PIX_W);
    localparam int TLO = field_lo(i, TEX_W);
    layer_addr_gen #(
      .SCALE_LOG2 (SCALE_LOG2),
      .WRAP_X     (WRAP_X),
      .SCROLL_STEP(SCROLL_STEP)
    ) u_gen (
      .clk        (clk),
      .rst        (rst),
      .x          (X),
      .y          (Y),
      .org_x      (layer_x[PLO +: PIX_W]),
      .org_y      (layer_y[PLO +: PIX_W]),
      .w          (layer_w[TLO +: TEX_W]),
      .h          (layer_h[TLO +: TEX_W]),
      .en         (layer_en[i]),
      .scroll_en  (scroll_en[i]),
      .scroll_tick(scroll_tick),
      .row        (rom_row[TLO +: TEX_W]),
      .col        (rom_col[TLO +: TEX_W]),
      .hit        (hit_s1[i])
    );
  end

  // Lowest-index opaque hit wins; the background carries its own dim flag in bit N.
  always_comb begin
    win_colour = BG_COLOUR;
    win_dim    = dim_s2[N];
    found      = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && hit_s2[i] &&
          rom_colour[field_lo(i, COLOUR_W) +: COLOUR_W] != KEY_COLOUR) begin
        win_colour = rom_colour[field_lo(i, COLOUR_W) +: COLOUR_W];
        win_dim    = dim_s2[i];
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      disp_s1   <= 1'b0;
      dim_s1    <= '0;
      hit_s2    <= '0;
      disp_s2   <= 1'b0;
      dim_s2    <= '0;
      RGB       <= '0;
      rgb_valid <= 1'b0;
    end else begin
      disp_s1   <= display_on;
      dim_s1    <= dim_mask;
      hit_s2    <= hit_s1;
      disp_s2   <= disp_s1;
      dim_s2    <= dim_s1;
      rgb_valid <= disp_s2;
      if (!disp_s2)     RGB <= '0;
      else if (win_dim) RGB <= win_colour & DIM_MASK;
      else              RGB <= win_colour;
    end
  end

endmodule
